// File: rtl/seg_pkg.sv
// Shared seven-segment constants: hex glyph table and blank pattern.
// Segment order {dp,g,f,e,d,c,b,a}, all active-low.
package seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [6:0] SEG_HEX_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam logic [6:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low segment pattern.
// A blanked digit turns off a-g but keeps its decimal point.
import seg_pkg::*;

module seg_hex_decode (
  input  logic [3:0] nib_i,
  input  logic       dp_i,
  input  logic       blank_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o = {~dp_i, SEG_HEX_LUT[nib_i]};
    if (blank_i) begin
      seg_o[6:0] = SEG_OFF;
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Double-buffered, blanked multiplex scanner for a common-anode display.
// Define SEG_LZ_BLANK_EN to suppress leading zeros.
import seg_pkg::*;

module seg_scan_driver #(
  parameter int DIGITS    = 6,
  parameter int CNT_SCAN  = 50_000,
  parameter int BLANK_CYC = 500
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  output logic                  pending,
  output logic                  frame_tick,
  output logic [DIGITS-1:0]     sel,
  output logic [7:0]            seg
);

  localparam int DW = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = (CNT_SCAN > 1) ? $clog2(CNT_SCAN) : 1;
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [CW-1:0] CNT_TOP   = CW'(CNT_SCAN - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(CNT_SCAN - 1 - BLANK_CYC);

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DW-1:0]     stg_data_q, stg_data_d;
  logic [DIGITS-1:0] stg_dp_q, stg_dp_d;
  logic [DW-1:0]     disp_data_q, disp_data_d;
  logic [DIGITS-1:0] disp_dp_q, disp_dp_d;
  logic              pend_q, pend_d;
  logic              tick_q;
  logic [DIGITS-1:0] sel_q, sel_d;
  logic [7:0]        seg_q, seg_d;

  logic              last_slot;
  logic              boundary;
  logic              in_blank;
  logic [3:0]        cur_nib;
  logic              cur_dp;
  logic              cur_blk;
  logic [7:0]        dec_seg;

`ifdef SEG_LZ_BLANK_EN
  localparam logic [DIGITS-1:0] LZ_RST = ~DIGITS'(1);
  logic [DIGITS-1:0] lz_q, lz_d;
  logic [DIGITS-1:0] lz_stg;
  logic              zero_above;

  // Digit i blanks when it and every digit above it are zero.
  always_comb begin
    lz_stg     = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_above = zero_above && (stg_data_q[4*i +: 4] == 4'h0);
      lz_stg[i]  = zero_above;
    end
  end
`endif

  always_comb begin
    last_slot = (cnt_q == '0);
    boundary  = last_slot && (idx_q == IDX_LAST);
    in_blank  = (cnt_q > CNT_BLANK);

    cnt_d = last_slot ? CNT_TOP : cnt_q - 1'b1;
    idx_d = idx_q;
    if (last_slot) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    disp_data_d = disp_data_q;
    disp_dp_d   = disp_dp_q;
    pend_d      = pend_q;
`ifdef SEG_LZ_BLANK_EN
    lz_d        = lz_q;
`endif
    if (boundary && pend_q) begin
      disp_data_d = stg_data_q;
      disp_dp_d   = stg_dp_q;
      pend_d      = 1'b0;
`ifdef SEG_LZ_BLANK_EN
      lz_d        = lz_stg;
`endif
    end

    stg_data_d = stg_data_q;
    stg_dp_d   = stg_dp_q;
    if (load) begin
      stg_data_d = data_in;
      stg_dp_d   = dp_in;
      pend_d     = 1'b1;
    end
  end

  always_comb begin
    cur_nib = '0;
    cur_dp  = 1'b0;
    cur_blk = 1'b0;
    sel_d   = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_nib  = disp_data_q[4*i +: 4];
        cur_dp   = disp_dp_q[i];
`ifdef SEG_LZ_BLANK_EN
        cur_blk  = lz_q[i];
`endif
        sel_d[i] = 1'b0;
      end
    end
    seg_d = dec_seg;
    if (in_blank) begin
      sel_d = '1;
      seg_d = SEG_BLANK;
    end
  end

  seg_hex_decode u_dec (
    .nib_i   (cur_nib),
    .dp_i    (cur_dp),
    .blank_i (cur_blk),
    .seg_o   (dec_seg)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q       <= CNT_TOP;
      idx_q       <= '0;
      stg_data_q  <= '0;
      stg_dp_q    <= '0;
      disp_data_q <= '0;
      disp_dp_q   <= '0;
      pend_q      <= 1'b0;
      tick_q      <= 1'b0;
      sel_q       <= '1;
      seg_q       <= SEG_BLANK;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      stg_data_q  <= stg_data_d;
      stg_dp_q    <= stg_dp_d;
      disp_data_q <= disp_data_d;
      disp_dp_q   <= disp_dp_d;
      pend_q      <= pend_d;
      tick_q      <= boundary;
      sel_q       <= sel_d;
      seg_q       <= seg_d;
    end
  end

`ifdef SEG_LZ_BLANK_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lz_q <= LZ_RST;
    end else begin
      lz_q <= lz_d;
    end
  end
`endif

  assign pending    = pend_q;
  assign frame_tick = tick_q;
  assign sel        = sel_q;
  assign seg        = seg_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench: a time-based display model predicts every output cycle.
// Build with SEG_LZ_BLANK_EN to exercise leading-zero blanking.
module tb_seg_scan_driver;

  localparam int DIGITS    = 6;
  localparam int CNT_SCAN  = 8;
  localparam int BLANK_CYC = 2;
  localparam int FRAME     = DIGITS * CNT_SCAN;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        load = 1'b0;
  logic [23:0] data_in = '0;
  logic [5:0]  dp_in = '0;
  logic        pending;
  logic        frame_tick;
  logic [5:0]  sel;
  logic [7:0]  seg;

  seg_scan_driver #(
    .DIGITS    (DIGITS),
    .CNT_SCAN  (CNT_SCAN),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .load       (load),
    .pending    (pending),
    .frame_tick (frame_tick),
    .sel        (sel),
    .seg        (seg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] sel;
    logic [7:0] seg;
    logic       pend;
    logic       tick;
  } obs_t;

  localparam obs_t RST_OBS = '{sel: 6'h3F, seg: 8'hFF, pend: 1'b0, tick: 1'b0};

  int   n_tests = 0;
  int   n_fail  = 0;
  obs_t exp_q[$];

  int          cyc = 0;
  logic [23:0] m_stg = '0;
  logic [23:0] m_disp = '0;
  logic [5:0]  m_sdp = '0;
  logic [5:0]  m_ddp = '0;
  bit          m_pend = 1'b0;

  function automatic logic [7:0] ref_seg(logic [23:0] v, logic [5:0] dp, int d);
    logic [3:0] nib;
    logic [7:0] code;
    int         hi;
    nib = v[4*d +: 4];
    case (nib)
      4'h0: code = 8'hC0; 4'h1: code = 8'hF9;
      4'h2: code = 8'hA4; 4'h3: code = 8'hB0;
      4'h4: code = 8'h99; 4'h5: code = 8'h92;
      4'h6: code = 8'h82; 4'h7: code = 8'hF8;
      4'h8: code = 8'h80; 4'h9: code = 8'h90;
      4'hA: code = 8'h88; 4'hB: code = 8'h83;
      4'hC: code = 8'hC6; 4'hD: code = 8'hA1;
      4'hE: code = 8'h86; default: code = 8'h8E;
    endcase
    hi = 0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] != 4'h0) hi = i;
    end
`ifdef SEG_LZ_BLANK_EN
    if (d > hi) code = 8'hFF;
`endif
    code[7] = ~dp[d];
    return code;
  endfunction

  task automatic check(string nm, obs_t act, obs_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got sel=%h seg=%h pend=%b tick=%b want sel=%h seg=%h pend=%b tick=%b",
               nm, $time, act.sel, act.seg, act.pend, act.tick,
               exp.sel, exp.seg, exp.pend, exp.tick);
    end
  endtask

  // Model: cycle cyc since reset release fixes the slot, digit and boundary.
  always @(posedge clk) begin
    obs_t e;
    int   pos;
    int   dig;
    bit   bnd;
    if (!rstn) begin
      cyc = 0; m_stg = '0; m_disp = '0;
      m_sdp = '0; m_ddp = '0; m_pend = 1'b0;
    end else begin
      pos = cyc % CNT_SCAN;
      dig = (cyc / CNT_SCAN) % DIGITS;
      bnd = (cyc % FRAME) == FRAME - 1;
      if (pos < BLANK_CYC) begin
        e.sel = 6'h3F;
        e.seg = 8'hFF;
      end else begin
        e.sel = ~(6'b1 << dig);
        e.seg = ref_seg(m_disp, m_ddp, dig);
      end
      e.tick = bnd;
      if (bnd && m_pend) begin
        m_disp = m_stg;
        m_ddp  = m_sdp;
        m_pend = 1'b0;
      end
      if (load) begin
        m_stg  = data_in;
        m_sdp  = dp_in;
        m_pend = 1'b1;
      end
      e.pend = m_pend;
      exp_q.push_back(e);
      cyc++;
    end
  end

  // Monitor: one comparison per clock, after the edge settles.
  always @(posedge clk) begin
    obs_t act;
    #1;
    act = '{sel: sel, seg: seg, pend: pending, tick: frame_tick};
    if (!rstn) begin
      check("reset_hold", act, RST_OBS);
    end else if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_empty t=%0t got sel=%h seg=%h", $time, sel, seg);
    end else begin
      check("scan", act, exp_q.pop_front());
    end
  end

  task automatic align(int m);
    int guard = 0;
    while ((cyc % FRAME) != m && guard < 4 * FRAME) begin
      @(negedge clk);
      guard++;
    end
    n_tests++;
    if (guard >= 4 * FRAME) begin
      n_fail++;
      $display("FAIL align got phase=%0d want %0d", cyc % FRAME, m);
    end
  endtask

  task automatic pulse_load(logic [23:0] d, logic [5:0] p);
    load    = 1'b1;
    data_in = d;
    dp_in   = p;
    @(negedge clk);
    load    = 1'b0;
  endtask

  task automatic frames(int k);
    repeat (k * FRAME) @(negedge clk);
  endtask

  initial begin
    obs_t act;
    repeat (3) @(negedge clk);
    act = '{sel: sel, seg: seg, pend: pending, tick: frame_tick};
    check("reset_vals", act, RST_OBS);
    rstn = 1'b1;
    frames(2);

    align(FRAME / 2);
    pulse_load(24'h123456, 6'b000001);
    frames(2);

    align(5);
    pulse_load(24'hAAAAAA, 6'h00);
    repeat (7) @(negedge clk);
    pulse_load(24'hBCDEF0, 6'h00);
    frames(2);

    align(10);
    pulse_load(24'h13579B, 6'h2A);
    align(FRAME - 1);
    pulse_load(24'h2468AC, 6'h15);
    frames(3);

    align(3 * CNT_SCAN + BLANK_CYC + 2);
    load = 1'b1;
    data_in = 24'hFFFFFF;
    rstn = 1'b0;
    #1;
    act = '{sel: sel, seg: seg, pend: pending, tick: frame_tick};
    check("reset_midscan", act, RST_OBS);
    @(negedge clk);
    @(negedge clk);
    load = 1'b0;
    rstn = 1'b1;
    frames(2);

    align(20);
    pulse_load(24'h000042, 6'h00);
    frames(2);
    pulse_load(24'h000000, 6'h00);
    frames(2);
    pulse_load(24'h000700, 6'h20);
    frames(2);

    repeat (1500) begin
      load    = ($urandom_range(0, 19) == 0);
      data_in = 24'($urandom);
      dp_in   = 6'($urandom);
      @(negedge clk);
    end
    load = 1'b0;
    frames(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Time-multiplexed driver for a 6-digit common-anode seven-segment display.
- Accepts a hex value plus decimal points from the control logic (for example, a counter advanced by debounced key pulses) and drives active-low digit selects and segments.
- Double-buffered: new values apply only at frame boundaries, so a digit never changes mid-frame.
- Inserts per-slot blanking to suppress ghosting.

Parameters:
- DIGITS, 6, number of digits scanned; index 0 is the rightmost digit.
- CNT_SCAN, 50_000, clk cycles per digit slot (1 ms at 50 MHz).
- BLANK_CYC, 500, cycles at the start of each slot with all digits off; must be less than CNT_SCAN.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- data_in  in  4*DIGITS  hex nibbles; nibble i shows on digit i
- dp_in  in  DIGITS  decimal point per digit; 1 = lit
- load  in  1  one-cycle strobe; captures data_in/dp_in into staging
- pending  out  1  staged value not yet displayed
- frame_tick  out  1  one-cycle pulse at each frame boundary
- sel  out  DIGITS  digit select, active-low, at most one bit low
- seg  out  8  segments, active-low, {dp,g,f,e,d,c,b,a}

Behaviour:
- Reset (asynchronous, active-low; clock clk):
  - sel = all 1; seg = 8'hFF; pending = 0; frame_tick = 0.
  - Staging and display registers = 0; digit index = 0; slot counter = CNT_SCAN-1.
- Slot counter:
  - Counts down each cycle.
  - At 0: reloads to CNT_SCAN-1 and advances the index 0→1→…→DIGITS-1→0.
- Blanking:
  - While counter > CNT_SCAN-1-BLANK_CYC (the first BLANK_CYC cycles of a slot): sel = all 1, seg = 8'hFF.
  - Otherwise: sel = ~(1<<index) and seg = decode(display nibble[index], display dp[index]).
  - sel and seg are both registered and mutually aligned: one cycle of latency from counter/index state.
- Decode table (hex → seg[6:0]):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8.
  - 8=80, 9=90, A=88, B=83, C=C6, D=A1, E=86, F=8E.
  - seg[7] = ~dp.
- Load:
  - load=1 → staging <= {data_in, dp_in}; pending <= 1.
  - Multiple loads before a boundary: the last one wins.
- Frame boundary (counter==0 and index==DIGITS-1):
  - frame_tick = 1 for that cycle (registered, so visible the next cycle).
  - If pending: display <= staging and pending <= 0.
- Load in the boundary cycle:
  - Display takes the previous staging value.
  - Staging takes the new data; pending stays 1, so the new value shows one frame later.
- Reset mid-frame: everything returns immediately to reset values; scanning restarts at digit 0 with a blank interval.
- load while rstn is low: ignored.

Optional Feature:
- Macro: SEG_LZ_BLANK_EN.
- Defined (leading-zero blanking):
  - Computed at the display transfer: every digit above the highest nonzero nibble is marked blank.
  - A blank digit drives seg[6:0] = 7'h7F; its dp is still honoured.
  - Digit 0 is never blanked; value 0 shows a single "0".
- Undefined: all digits always show their nibble.
- Slot timing is identical in both builds.

Decomposition:
- Package seg_pkg:
  - Constant array SEG_HEX_LUT[16] of 7-bit codes.
  - SEG_BLANK = 8'hFF.
  - Shared with other display blocks.
- Sub-module seg_hex_decode: purely combinational; nibble + dp + blank → 8-bit seg.
- Counter, index, double buffer and output registers stay in seg_scan_driver.

Test Plan (DIGITS=6, CNT_SCAN=8, BLANK_CYC=2):
- Reset and blanking:
  - Stimulus: hold rstn=0, then release.
  - Required: sel=6'h3F and seg=8'hFF during reset.
  - Required: after release, sel=6'h3F for the first 2 slot cycles of every slot, then 6'h3E, 6'h3D, … in turn, 6 active cycles each.
- Display update:
  - Stimulus: load 24'h123456, dp_in=6'b000001.
  - Required: pending=1 until the next boundary; display unchanged until then.
  - Required: at the boundary, frame_tick pulses once and pending drops to 0.
  - Required: next frame shows digit0 seg=8'h02 (6 + dp lit) with sel=3E, and digit5 seg=8'hF9 with sel=1F.
- Back-to-back loads:
  - Stimulus: load 24'hAAAAAA, then 24'hBCDEF0, within one frame.
  - Required: next frame shows only BCDEF0; digit0 = C0, digit5 = 83.
- Load on boundary:
  - Stimulus: load X mid-frame; load Y exactly on the boundary cycle.
  - Required: X shows for one frame with pending=1 throughout; Y shows in the following frame and pending then clears.
- Reset mid-scan:
  - Stimulus: assert rstn during digit 3 active time.
  - Required: outputs go blank immediately and the display reads 000000 after the first frame.
- SEG_LZ_BLANK_EN build:
  - Stimulus: load 24'h000042.
  - Required: digits 2–5 seg=FF, digit1=99, digit0=A4.
  - Stimulus: load 24'h000000.
  - Required: only digit0 shows C0.
